// File: rtl/mram_access_sequencer.sv
// MRAM access sequencer: runs one access per request (shift address/data, strobe the MRAM, optionally
// unload read data) through the STP/PTS shift modules. Every output is registered.
module mram_access_sequencer #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 16,
  parameter int ACCESS_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic       req_write,
  input  logic [1:0] req_be,
  output logic       busy,
  output logic       done,
  output logic       data_en,
  output logic       addr_en,
  output logic       send_data,
  output logic       load,
  output logic       data_in_from_MRAM_en,
  output logic       chip_en,
  output logic       write_en,
  output logic       out_en,
  output logic       lower_byte_en,
  output logic       upper_byte_en
);

  localparam int CW = $clog2(ADDR_W + 1);
  localparam logic [CW-1:0] CNT_ADDR = CW'(ADDR_W);
  localparam logic [CW-1:0] CNT_ACC  = CW'(ACCESS_CYC);
  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_W);
  localparam logic [CW-1:0] CNT_HALF = CW'(DATA_W / 2);
  localparam logic [CW-1:0] DATA_TH  = CW'(ADDR_W - DATA_W);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_ACCESS, S_LOAD, S_UNLOAD, S_DONE
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          wr_q, wr_n;
  logic [1:0]    be_q, be_n;
  logic          cnt_last;

  logic busy_n, done_n, data_en_n, addr_en_n, send_data_n, load_n, pts_en_n;
  logic chip_en_n, write_en_n, out_en_n, lower_n, upper_n;

  assign cnt_last = (cnt == CNT_ONE);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    wr_n    = wr_q;
    be_n    = be_q;
    case (state)
      S_IDLE: begin
        if (req) begin
          wr_n = req_write;
          be_n = req_be;
          if (req_be == 2'b00) begin
            state_n = S_DONE;
          end else begin
            state_n = S_SHIFT;
            cnt_n   = CNT_ADDR;
          end
        end
      end
      S_SHIFT: begin
        if (cnt_last) begin
          state_n = S_ACCESS;
          cnt_n   = CNT_ACC;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      S_ACCESS: begin
        if (cnt_last) begin
          state_n = wr_q ? S_DONE : S_LOAD;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      S_LOAD: begin
        state_n = S_UNLOAD;
        cnt_n   = (be_q == 2'b11) ? CNT_FULL : CNT_HALF;
      end
      S_UNLOAD: begin
        if (cnt_last) begin
          state_n = S_DONE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so the registers line up with the state they describe.
  always_comb begin
    busy_n      = (state_n != S_IDLE);
    done_n      = 1'b0;
    data_en_n   = 1'b0;
    addr_en_n   = 1'b0;
    send_data_n = 1'b0;
    load_n      = 1'b0;
    pts_en_n    = 1'b0;
    chip_en_n   = 1'b1;
    write_en_n  = 1'b1;
    out_en_n    = 1'b1;
    lower_n     = 1'b1;
    upper_n     = 1'b1;
    case (state_n)
      S_SHIFT: begin
        addr_en_n = 1'b1;
        data_en_n = wr_n && (cnt_n > DATA_TH);
      end
      S_ACCESS: begin
        chip_en_n   = 1'b0;
        send_data_n = 1'b1;
        write_en_n  = ~wr_n;
        out_en_n    = wr_n;
        lower_n     = ~be_n[0];
        upper_n     = ~be_n[1];
      end
      S_LOAD: begin
        chip_en_n = 1'b0;
        out_en_n  = 1'b0;
        lower_n   = ~be_n[0];
        upper_n   = ~be_n[1];
        load_n    = 1'b1;
        pts_en_n  = 1'b1;
      end
      S_UNLOAD: begin
        pts_en_n    = 1'b1;
        send_data_n = 1'b1;
      end
      S_DONE:  done_n = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= S_IDLE;
      cnt                  <= '0;
      wr_q                 <= 1'b0;
      be_q                 <= '0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      data_en              <= 1'b0;
      addr_en              <= 1'b0;
      send_data            <= 1'b0;
      load                 <= 1'b0;
      data_in_from_MRAM_en <= 1'b0;
      chip_en              <= 1'b1;
      write_en             <= 1'b1;
      out_en               <= 1'b1;
      lower_byte_en        <= 1'b1;
      upper_byte_en        <= 1'b1;
    end else begin
      state                <= state_n;
      cnt                  <= cnt_n;
      wr_q                 <= wr_n;
      be_q                 <= be_n;
      busy                 <= busy_n;
      done                 <= done_n;
      data_en              <= data_en_n;
      addr_en              <= addr_en_n;
      send_data            <= send_data_n;
      load                 <= load_n;
      data_in_from_MRAM_en <= pts_en_n;
      chip_en              <= chip_en_n;
      write_en             <= write_en_n;
      out_en               <= out_en_n;
      lower_byte_en        <= lower_n;
      upper_byte_en        <= upper_n;
    end
  end

endmodule

// File: tb/tb_mram_access_sequencer.sv
// Bench for mram_access_sequencer: a default instance and a 24/8/3 instance, checked every cycle
// against a timeline model indexed by cycles since the accepting edge.
module tb_mram_access_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req [2];
  logic       wr  [2];
  logic [1:0] be  [2];
  logic busy[2], done[2], data_en[2], addr_en[2], send_data[2], load[2], pts_en[2];
  logic chip_en[2], write_en[2], out_en[2], lower_en[2], upper_en[2];
  logic [11:0] outv [2];

  int checks = 0;
  int failures = 0;

  int pa [2] = '{20, 24};
  int pd [2] = '{16, 8};
  int pc [2] = '{2, 3};

  always #5 clk = ~clk;

  mram_access_sequencer #(.ADDR_W(20), .DATA_W(16), .ACCESS_CYC(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req[0]), .req_write(wr[0]), .req_be(be[0]),
    .busy(busy[0]), .done(done[0]), .data_en(data_en[0]), .addr_en(addr_en[0]),
    .send_data(send_data[0]), .load(load[0]), .data_in_from_MRAM_en(pts_en[0]),
    .chip_en(chip_en[0]), .write_en(write_en[0]), .out_en(out_en[0]),
    .lower_byte_en(lower_en[0]), .upper_byte_en(upper_en[0]));

  mram_access_sequencer #(.ADDR_W(24), .DATA_W(8), .ACCESS_CYC(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req[1]), .req_write(wr[1]), .req_be(be[1]),
    .busy(busy[1]), .done(done[1]), .data_en(data_en[1]), .addr_en(addr_en[1]),
    .send_data(send_data[1]), .load(load[1]), .data_in_from_MRAM_en(pts_en[1]),
    .chip_en(chip_en[1]), .write_en(write_en[1]), .out_en(out_en[1]),
    .lower_byte_en(lower_en[1]), .upper_byte_en(upper_en[1]));

  // {busy,done,data_en,addr_en,send_data,load,pts_en,chip_en,write_en,out_en,lower,upper}
  assign outv[0] = {busy[0], done[0], data_en[0], addr_en[0], send_data[0], load[0], pts_en[0],
                    chip_en[0], write_en[0], out_en[0], lower_en[0], upper_en[0]};
  assign outv[1] = {busy[1], done[1], data_en[1], addr_en[1], send_data[1], load[1], pts_en[1],
                    chip_en[1], write_en[1], out_en[1], lower_en[1], upper_en[1]};

  localparam logic [11:0] IDLE_V = 12'b0000_0001_1111;

  function automatic int acc_len(bit w, logic [1:0] b, int a, int d, int c);
    if (b == 2'b00) return 1;
    if (w) return a + c + 1;
    return a + c + 1 + ((b == 2'b11) ? d : d / 2) + 1;
  endfunction

  // Expected outputs in cycle t (t=1 is the cycle after the accepting edge).
  function automatic logic [11:0] exp_out(bit act, int t, bit w, logic [1:0] b, int a, int d, int c);
    logic [11:0] v;
    int len;
    v = IDLE_V;
    if (!act) return v;
    len = acc_len(w, b, a, d, c);
    v[11] = 1'b1;
    if (t == len) begin
      v[10] = 1'b1;
    end else if (t <= a) begin
      v[8] = 1'b1;
      v[9] = w && (t <= d);
    end else if (t <= a + c) begin
      v[7] = 1'b1; v[4] = 1'b0;
      v[3] = ~w;   v[2] = w;
      v[1] = ~b[0]; v[0] = ~b[1];
    end else if (t == a + c + 1) begin
      v[6] = 1'b1; v[5] = 1'b1; v[4] = 1'b0; v[3] = 1'b1; v[2] = 1'b0;
      v[1] = ~b[0]; v[0] = ~b[1];
    end else begin
      v[5] = 1'b1; v[7] = 1'b1;
    end
    return v;
  endfunction

  bit         m_act [2] = '{1'b0, 1'b0};
  int         m_t   [2] = '{0, 0};
  bit         m_w   [2];
  logic [1:0] m_be  [2];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_act[i] = 1'b0;
      end else if (!m_act[i]) begin
        if (req[i]) begin
          m_act[i] = 1'b1; m_t[i] = 1; m_w[i] = wr[i]; m_be[i] = be[i];
        end
      end else if (m_t[i] == acc_len(m_w[i], m_be[i], pa[i], pd[i], pc[i])) begin
        m_act[i] = 1'b0;
      end else begin
        m_t[i] = m_t[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [11:0] e;
      e = exp_out(m_act[i], m_t[i], m_w[i], m_be[i], pa[i], pd[i], pc[i]);
      checks++;
      if (outv[i] !== e) begin
        failures++;
        $display("FAIL cycle_outputs inst%0d t=%0d @%0t: got %b expected %b", i, m_t[i], $time, outv[i], e);
      end
    end
  end

  task automatic do_req(input int i, input bit w, input logic [1:0] b, input int exp_lat);
    int n;
    bit seen;
    @(negedge clk);
    req[i] = 1'b1; wr[i] = w; be[i] = b;
    @(posedge clk);
    n = 0; seen = 1'b0;
    while (!seen && n < 300) begin
      @(negedge clk);
      n++;
      req[i] = 1'b0;
      if (done[i] === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || n != exp_lat) begin
      failures++;
      $display("FAIL latency inst%0d w=%0d be=%b: got %0d expected %0d", i, w, b, n, exp_lat);
    end
    @(negedge clk);
  endtask

  initial begin
    int ndone;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; wr[i] = 1'b0; be[i] = 2'b00;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (outv[0] !== 12'h01F) begin
      failures++;
      $display("FAIL reset_state: got %b expected %b", outv[0], 12'h01F);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_req(0, 1'b1, 2'b11, 23);
    do_req(0, 1'b0, 2'b11, 40);
    do_req(0, 1'b0, 2'b10, 32);
    do_req(0, 1'b0, 2'b01, 32);
    do_req(0, 1'b1, 2'b01, 23);
    do_req(0, 1'b1, 2'b00, 1);

    // req pulsed while busy must be dropped
    @(negedge clk);
    req[0] = 1'b1; wr[0] = 1'b1; be[0] = 2'b11;
    @(negedge clk); req[0] = 1'b0;
    repeat (9) @(negedge clk);
    req[0] = 1'b1; wr[0] = 1'b0;
    @(negedge clk); req[0] = 1'b0;
    ndone = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done[0] === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 1) begin
      failures++;
      $display("FAIL ignored_req: got %0d done pulses expected 1", ndone);
    end

    // req held high: back-to-back writes with one idle cycle between
    req[0] = 1'b1; wr[0] = 1'b1; be[0] = 2'b11;
    ndone = 0;
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      if (done[0] === 1'b1) ndone++;
    end
    req[0] = 1'b0;
    checks++;
    if (ndone != 2) begin
      failures++;
      $display("FAIL back_to_back: got %0d done pulses expected 2", ndone);
    end
    repeat (30) @(negedge clk);

    // asynchronous reset in the middle of a write access
    req[0] = 1'b1; wr[0] = 1'b1; be[0] = 2'b11;
    @(posedge clk);
    @(negedge clk); req[0] = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (chip_en[0] !== 1'b0 || write_en[0] !== 1'b0) begin
      failures++;
      $display("FAIL access_before_reset: got chip_en=%b write_en=%b expected 0 0", chip_en[0], write_en[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (outv[0] !== 12'h01F) begin
      failures++;
      $display("FAIL async_reset: got %b expected %b", outv[0], 12'h01F);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    do_req(0, 1'b1, 2'b11, 23);

    do_req(1, 1'b1, 2'b11, 28);
    do_req(1, 1'b0, 2'b11, 37);
    do_req(1, 1'b0, 2'b01, 33);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
